// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for N_REQ requesters.
// The grant is issued both as a one-hot vector and as a binary index, and
// all grant outputs are registered. An owner keeps the grant until it drops
// its request. On release the grant passes in the same edge to the next
// pending requester after the owner.
// Optional feature: define RR_ARB_TIMEOUT_EN to limit tenure to TIMEOUT
// cycles while another requester is pending.
module rr_onehot_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT_LSB = N_REQ'(1);

  state_t           state;
  logic [IDX_W-1:0] ptr;          // highest-priority requester when idle
  logic [IDX_W-1:0] owner_next;   // owner + 1, wrapped modulo N_REQ
  logic             owner_req;    // current owner still requesting
  logic [N_REQ-1:0] search_vec;
  int               search_start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tenure;
`endif

  assign owner_next = (gnt_idx_o == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
  assign owner_req  = req_i[gnt_idx_o];

  // Pick the first pending requester, starting at ptr when idle, or just past
  // the owner (owner excluded) when a grant is active.
  always_comb begin
    // NOTE: every signal written here is given a default first. A path that
    // leaves one unassigned would infer a latch.
    search_vec   = req_i;
    search_start = int'(ptr);
    pick_found   = 1'b0;
    pick_idx     = '0;
    if (state == GRANT) begin
      search_vec   = req_i & ~gnt_o;
      search_start = int'(owner_next);
    end
    // Scan from the farthest offset down to the nearest, so the nearest
    // pending requester is the last one written and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int k;
      k = search_start + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (search_vec[k]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  // Grant state machine: the state, the pointer, the tenure counter and all
  // three grant outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments, so every branch
    // reads the values from before this edge.
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      tenure      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= GRANT;
            gnt_o       <= ONE_HOT_LSB << pick_idx;
            gnt_idx_o   <= pick_idx;
            gnt_valid_o <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            tenure      <= CNT_W'(1);
`endif
          end
        end

        GRANT: begin
          if (!owner_req) begin
            // Owner released: hand off without a bubble, or go idle.
            ptr <= owner_next;
            if (pick_found) begin
              gnt_o     <= ONE_HOT_LSB << pick_idx;
              gnt_idx_o <= pick_idx;
`ifdef RR_ARB_TIMEOUT_EN
              tenure    <= CNT_W'(1);
`endif
            end else begin
              state       <= IDLE;
              gnt_o       <= '0;
              gnt_idx_o   <= '0;
              gnt_valid_o <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
              tenure      <= '0;
`endif
            end
          end
`ifdef RR_ARB_TIMEOUT_EN
          else if (tenure == CNT_W'(TIMEOUT) && pick_found) begin
            // Tenure used up while others wait: preempt the owner.
            ptr       <= owner_next;
            gnt_o     <= ONE_HOT_LSB << pick_idx;
            gnt_idx_o <= pick_idx;
            tenure    <= CNT_W'(1);
          end else if (tenure != CNT_W'(TIMEOUT)) begin
            tenure <= tenure + CNT_W'(1);
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Testbench for rr_onehot_arbiter with N_REQ=4 and TIMEOUT=8.
// The stimulus process drives req_i and queues the grant expected after the
// next rising edge. The monitor process checks each queued entry against the
// outputs shortly after that edge.
module tb_rr_onehot_arbiter;

  localparam int N_REQ   = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] idx;
    logic             valid;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             gnt_valid_o;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  rr_onehot_arbiter #(
    .N_REQ  (N_REQ),
    .IDX_W  (IDX_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx_o),
    .gnt_valid_o(gnt_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one request vector and queue the grant expected after the next edge.
  task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] eg,
                      input int ei, input logic ev);
    exp_t e;
    @(negedge clk);
    req_i   = r;
    e.gnt   = eg;
    e.idx   = ei[IDX_W-1:0];
    e.valid = ev;
    exp_q.push_back(e);
  endtask

  task automatic step_n(input int n, input logic [N_REQ-1:0] r,
                        input logic [N_REQ-1:0] eg, input int ei, input logic ev);
    for (int i = 0; i < n; i++) step(r, eg, ei, ev);
  endtask

  // Monitor: after each rising edge, compare the outputs with the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt_o", 32'(gnt_o), 32'(e.gnt));
        check("gnt_valid_o", 32'(gnt_valid_o), 32'(e.valid));
        if (e.valid) check("gnt_idx_o", 32'(gnt_idx_o), 32'(e.idx));
        check("invariant_onehot_valid",
              32'({$onehot0(gnt_o), gnt_valid_o == (gnt_o != '0)}), 32'b11);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_i = '0;

    // 1. Reset held for three cycles with no requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_gnt", 32'(gnt_o), 32'h0);
      check("reset_idx", 32'(gnt_idx_o), 32'h0);
      check("reset_valid", 32'(gnt_valid_o), 32'h0);
    end
    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 0, 1'b0);

    // 2. Single requester 2 holds for five cycles, then releases (ptr -> 3).
    step_n(5, 4'b0100, 4'b0100, 2, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b0);

    // 3. All requesting: the first grant goes to 3, then the order rotates
    //    0,1,2,3,0 with each owner holding two cycles and no idle gap.
    step(4'b1111, 4'b1000, 3, 1'b1);
    step(4'b1111, 4'b1000, 3, 1'b1);
    step(4'b0111, 4'b0001, 0, 1'b1);
    step(4'b1111, 4'b0001, 0, 1'b1);
    step(4'b1110, 4'b0010, 1, 1'b1);
    step(4'b1111, 4'b0010, 1, 1'b1);
    step(4'b1101, 4'b0100, 2, 1'b1);
    step(4'b1111, 4'b0100, 2, 1'b1);
    step(4'b1011, 4'b1000, 3, 1'b1);
    step(4'b1111, 4'b1000, 3, 1'b1);
    step(4'b0111, 4'b0001, 0, 1'b1);
    step(4'b1111, 4'b0001, 0, 1'b1);
    step(4'b1110, 4'b0010, 1, 1'b1);
    step(4'b1101, 4'b0100, 2, 1'b1);
    step(4'b1011, 4'b1000, 3, 1'b1);

    // 4. Owner 3 releases with only requester 1 pending: wrap past 0 to 1.
    step(4'b0010, 4'b0010, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b0);  // ptr -> 2

    // 5. Reset pulsed between edges during a grant of 3.
    step(4'b1000, 4'b1000, 3, 1'b1);
    @(posedge clk);
    #2;
    check("pre_reset_gnt", 32'(gnt_o), 32'h8);
    #1;
    rst_n = 1'b0;
    req_i = '0;
    #1;
    check("async_reset_gnt", 32'(gnt_o), 32'h0);
    check("async_reset_valid", 32'(gnt_valid_o), 32'h0);
    check("async_reset_idx", 32'(gnt_idx_o), 32'h0);
    rst_n = 1'b1;
    // With ptr reset to 0, request 1010 picks 1. A stale ptr of 2 would pick 3.
    step(4'b1010, 4'b0010, 1, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b0);  // ptr -> 2
    step(4'b1000, 4'b1000, 3, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b0);  // ptr -> 0

    // 6. Requests 0011 held continuously, then requester 0 alone.
`ifdef RR_ARB_TIMEOUT_EN
    step_n(TIMEOUT, 4'b0011, 4'b0001, 0, 1'b1);
    step_n(TIMEOUT, 4'b0011, 4'b0010, 1, 1'b1);
    step(4'b0011, 4'b0001, 0, 1'b1);
`else
    step_n(2 * TIMEOUT + 1, 4'b0011, 4'b0001, 0, 1'b1);
`endif
    step_n(12, 4'b0001, 4'b0001, 0, 1'b1);
    step(4'b0000, 4'b0000, 0, 1'b0);

    // Let the monitor drain the queue, within a fixed cycle budget.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource among N_REQ requesters.
- Issues the grant in two forms:
  - a one-hot vector (the same encoding our binary-to-one-hot decoder produces);
  - a binary index.
- Sits in front of any shared datapath (bus, decoder-driven mux, memory port).
- A grant is held until the owning requester drops its request.

Parameters:
N_REQ, 4, number of requesters (2..16)
IDX_W, 2, binary index width; must equal ceil(log2(N_REQ))
TIMEOUT, 8, maximum grant tenure in cycles when RR_ARB_TIMEOUT_EN is defined (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_i  input  N_REQ  request vector; bit k = requester k wants the resource
gnt_o  output  N_REQ  registered one-hot grant; all-zero when no owner
gnt_idx_o  output  IDX_W  registered binary index of owner; valid only when gnt_valid_o=1
gnt_valid_o  output  1  registered; 1 while any grant is active (equals OR of gnt_o)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-grant):
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0.
  - Priority pointer ptr=0, state=IDLE, tenure counter=0.
  - Outputs clear immediately, without waiting for clk.
- State IDLE (no owner):
  - At each edge, if req_i!=0, grant the first set bit searching from ptr upward, wrapping modulo N_REQ. Go to GRANT.
  - Latency: a request sampled at edge n is granted in outputs after edge n.
  - If req_i=0, stay in IDLE with outputs zero.
- State GRANT (owner = gnt_idx_o):
  - Owner's req_i bit high: hold the grant unchanged, regardless of other requests.
  - Owner's req_i bit sampled low: ptr <= owner+1 (mod N_REQ).
    - If any other req_i bit is set, hand off in the same edge to the first set bit searching from owner+1 (owner excluded). No bubble cycle.
    - Otherwise clear the grant and go to IDLE.
- Fairness: with all requesters continuously re-requesting, the grant order is 0,1,...,N_REQ-1,0,... No requester waits more than N_REQ-1 tenures.
- Wrap-around: the search from ptr=N_REQ-1 continues at 0. For N_REQ not a power of 2, indices >= N_REQ never appear.
- Invariants:
  - gnt_o has at most one bit set.
  - gnt_o[gnt_idx_o]==1 whenever gnt_valid_o=1.
  - gnt_o==0 iff gnt_valid_o=0.
- A request bit that rises and falls between edges is not seen. Requesters must hold req until granted.
- Granting is fully synchronous; only reset is asynchronous.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN
- Defined:
  - A tenure counter resets to 1 on each new grant and increments each cycle the grant is held.
  - When the counter reaches TIMEOUT and another requester is pending, the owner is preempted at that edge.
  - The grant moves to the next pending requester in round-robin order from owner+1, and ptr <= owner+1.
  - The preempted requester may re-win later through normal rotation.
  - If no other request is pending, the owner keeps the grant and the counter saturates at TIMEOUT.
- Not defined: no counter logic; the owner holds the grant indefinitely while its request stays high.

Test Plan (N_REQ=4, TIMEOUT=8):
1. Reset then idle: rst_n low 3 cycles, req_i=0000 -> gnt_o=0000, gnt_idx_o=0, gnt_valid_o=0 throughout.
2. Single requester: req_i=0100 at edge n, held 5 cycles, then 0000 -> gnt_o=0100 and gnt_idx_o=2 after edge n for 5 cycles, then 0000. Next grant for 1111 goes to idx 3.
3. Rotation: req_i=1111, each owner drops its bit for 1 cycle after 2 cycles of tenure -> grant sequence idx 0,1,2,3,0 with no idle bubble between grants.
4. Wrap and skip: owner idx 3 releases while req_i=0010 -> next grant idx 1, gnt_o=0010, same edge.
5. Async reset mid-grant: gnt_o=1000, rst_n pulsed low between edges -> gnt_o=0000 before the next clk edge. After release with req_i=1000, grant returns to idx 3, with ptr back at 0.
6. Timeout (macro defined): req_i=0011 held continuously -> idx 0 holds 8 cycles, then idx 1 for 8 cycles, then idx 0. With req_i=0001 only, idx 0 holds indefinitely. Macro undefined: idx 0 holds for the whole 0011 run.
